// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative RV32M multiply/divide engine for the EX stage.
//            MUL/MULH/MULHSU/MULHU use a shift-add multiplier on operand
//            magnitudes, one multiplier bit per cycle. DIV/DIVU/REM/REMU
//            use restoring division, one quotient bit per cycle. Divide by
//            zero and signed overflow finish in a single cycle.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            start_i   - EX holds a valid M-extension instruction
//            op_i      - funct3 (0 MUL .. 7 REMU)
//            rs1_i     - operand A (multiplicand / dividend)
//            rs2_i     - operand B (multiplier / divisor)
//            flush_i   - abort any in-flight operation
//            busy_o    - stall request to upstream pipeline registers
//            done_o    - one-cycle pulse, result_o valid
//            result_o  - last completed result, held until the next one
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int            CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        op_q;        // funct3[1:0]; MUL vs DIV is implied by state
  logic              neg_res_q;   // negate product / quotient
  logic              neg_rem_q;   // negate remainder
  logic [2*XLEN-1:0] mcand_q;     // multiplicand, shifted left each cycle
  logic [XLEN-1:0]   mplier_q;    // multiplier, shifted right each cycle
  logic [2*XLEN-1:0] prod_q;      // partial product accumulator
  logic [XLEN-1:0]   quo_q;       // dividend shifting out / quotient shifting in
  logic [XLEN-1:0]   rem_q;       // partial remainder
  logic [XLEN-1:0]   dvsr_q;      // divisor magnitude
  logic [XLEN-1:0]   result_q;

  // --------------------------------------------------------------------------
  // Operand decode at accept time
  // --------------------------------------------------------------------------
  logic              accept;
  logic              a_signed, b_signed;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    accept   = (state_q == S_IDLE) && start_i && !flush_i;
    // MUL low half is sign-agnostic, so it is handled as signed x signed.
    a_signed = (op_i == 3'd0) || (op_i == 3'd1) || (op_i == 3'd2) ||
               (op_i == 3'd4) || (op_i == 3'd6);
    b_signed = (op_i == 3'd0) || (op_i == 3'd1) ||
               (op_i == 3'd4) || (op_i == 3'd6);
    sa       = a_signed && rs1_i[XLEN-1];
    sb       = b_signed && rs2_i[XLEN-1];
    // Negating MIN_NEG yields MIN_NEG, which is exactly 2^(XLEN-1) unsigned.
    a_mag    = sa ? (~rs1_i + 1'b1) : rs1_i;
    b_mag    = sb ? (~rs2_i + 1'b1) : rs2_i;
    div_zero = op_i[2] && (rs2_i == '0);
    div_ovf  = op_i[2] && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    special  = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = op_i[1] ? rs1_i : '1;
    end else if (div_ovf) begin
      special_res = op_i[1] ? '0 : MIN_NEG;
    end
  end

  // --------------------------------------------------------------------------
  // Iteration step logic
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] mul_sum, mul_fin;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, rem_nxt, quo_nxt, div_res;
  logic              last_iter;

  always_comb begin
    last_iter = (cnt_q == CNT_LAST);

    mul_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
    mul_fin = neg_res_q ? (~mul_sum + 1'b1) : mul_sum;
    mul_res = (op_q == 2'd0) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];

    // Partial remainder is always below the divisor, so the shifted value
    // minus the divisor fits in XLEN bits whenever the subtraction is taken.
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, dvsr_q});
    div_diff  = div_shift[XLEN-1:0] - dvsr_q;
    rem_nxt   = div_ge ? div_diff : div_shift[XLEN-1:0];
    quo_nxt   = {quo_q[XLEN-2:0], div_ge};
    if (op_q[1]) begin
      div_res = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
    end else begin
      div_res = neg_res_q ? (~quo_nxt + 1'b1) : quo_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (special)      state_d = S_DONE;
            else if (op_i[2]) state_d = S_DIV;
            else              state_d = S_MUL;
          end
        end
        S_MUL:   if (last_iter) state_d = S_DONE;
        S_DIV:   if (last_iter) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;   // a start_i seen here is the same instruction
        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_IDLE:  busy_o = start_i;
      S_MUL:   busy_o = 1'b1;
      S_DIV:   busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign result_o = result_q;

  // --------------------------------------------------------------------------
  // Datapath registers. result_q is written only on the edge into DONE, so a
  // flush (which forces IDLE) never disturbs the previously returned value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= op_i[1:0];
      neg_res_q <= sa ^ sb;
      neg_rem_q <= sa;
      mcand_q   <= {{XLEN{1'b0}}, a_mag};
      mplier_q  <= b_mag;
      prod_q    <= '0;
      quo_q     <= a_mag;
      rem_q     <= '0;
      dvsr_q    <= b_mag;
      if (special) begin
        result_q <= special_res;
      end
    end else if (!flush_i && (state_q == S_MUL)) begin
      cnt_q    <= cnt_q + CW'(1);
      prod_q   <= mul_sum;
      mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
      if (last_iter) begin
        result_q <= mul_res;
      end
    end else if (!flush_i && (state_q == S_DIV)) begin
      cnt_q <= cnt_q + CW'(1);
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      if (last_iter) begin
        result_q <= div_res;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Directed self-checking bench for ex_muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  int tests = 0;
  int fails = 0;
  logic [XLEN-1:0] last_res;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge of an IDLE cycle (cycle N). Returns at the negedge of
  // the cycle following done_o, so a second call starts back-to-back.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    int busy_cnt;
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    #1;
    busy_cnt = busy_o ? 1 : 0;
    @(negedge clk);
    start_i = 1'b0;
    rs1_i   = '0;
    rs2_i   = '0;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      if (busy_o) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_busycycles"}, busy_cnt, lat);
    check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check({tag, "_busy_in_done"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_result"}, result_o, exp);
    last_res = exp;
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, "_hold"}, result_o, exp);
  endtask

  initial begin
    int seen;
    rst      = 1'b1;
    start_i  = 1'b0;
    op_i     = 3'd0;
    rs1_i    = '0;
    rs2_i    = '0;
    flush_i  = 1'b0;
    last_res = '0;
    #1;
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Multiplies
    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh",   3'd1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mul_big", 3'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 33);

    // Divides
    run_op("div",    3'd4, 32'hFFFF_FFEC, 32'd3,  32'hFFFF_FFFA, 33);
    run_op("rem",    3'd6, 32'hFFFF_FFEC, 32'd3,  32'hFFFF_FFFE, 33);
    run_op("divu",   3'd5, 32'd100,       32'd7,  32'd14,        33);
    run_op("remu",   3'd7, 32'd100,       32'd7,  32'd2,         33);
    run_op("div_minneg", 3'd4, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

    // Special cases
    run_op("div_by0",  3'd4, 32'd123,       32'd0,         32'hFFFF_FFFF, 1);
    run_op("divu_by0", 3'd5, 32'd9,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_by0",  3'd6, 32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("divu_noovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       33);

    // Flush at cycle N+10 of a DIV
    start_i = 1'b1; op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_done", {31'd0, done_o}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) seen++;
      @(negedge clk);
    end
    check("flush_no_done", seen, 0);
    check("flush_result_kept", result_o, last_res);

    // Back-to-back after the flush, then MUL followed directly by DIV
    run_op("b2b_mul", 3'd0, 32'd12, 32'd11, 32'd132, 33);
    run_op("b2b_div", 3'd5, 32'd132, 32'd12, 32'd11, 33);

    // Reset mid-MUL
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_busy", {31'd0, busy_o}, 32'd0);
    check("rstmid_done", {31'd0, done_o}, 32'd0);
    check("rstmid_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) seen++;
      @(negedge clk);
    end
    check("rstmid_no_done", seen, 0);
    run_op("after_rst", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
